// File: rtl/sgdmac_pkg.sv
// Shared types and constants for the scatter-gather DMA read path.
package sgdmac_pkg;

    localparam int CMD_W         = 48;
    localparam int AXI_MAX_BEATS = 16;
    localparam int PAGE_BYTES    = 4096;
    // Wide enough to hold a beat count of 1..AXI_MAX_BEATS.
    localparam int BEATS_W       = $clog2(AXI_MAX_BEATS) + 1;

    // Transfer command as popped from the read command FIFO.
    typedef struct packed {
        logic [31:0] addr;
        logic [15:0] byte_len;
    } sgdmac_cmd_t;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        ISSUE
    } splitter_state_e;

    function automatic logic [13:0] min_words(input logic [13:0] a, input logic [13:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/sgdmac_space_tracker.sv
// Tracks data FIFO space promised to bursts that are issued but whose data
// has not yet arrived, and tells the splitter whether the next burst fits.
module sgdmac_space_tracker
    import sgdmac_pkg::*;
#(
    parameter int FIFO_DEPTH = 128
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [$clog2(FIFO_DEPTH):0]  fifo_cnt_i,
    input  logic                         fifo_wren_i,
    input  logic                         issue_i,
    input  logic [BEATS_W-1:0]           beats_i,
    output logic                         space_ok_o,
    output logic                         idle_o
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [CNT_W-1:0] reserved_q;
    logic [CNT_W-1:0] reserved_d;
    logic [CNT_W:0]   free;

    // One extra bit so the subtraction matches the documented unsigned width.
    assign free       = (CNT_W+1)'(FIFO_DEPTH) - (CNT_W+1)'(fifo_cnt_i) - (CNT_W+1)'(reserved_q);
    assign space_ok_o = (free >= (CNT_W+1)'(beats_i));
    assign idle_o     = (reserved_q == '0);

    // Net reservation change: add a newly issued burst, retire one arriving word.
    always_comb begin
        // NOTE: default assigned first so every path drives reserved_d and no latch is inferred.
        reserved_d = reserved_q;
        if (issue_i) begin
            reserved_d = reserved_d + CNT_W'(beats_i);
        end
        if (fifo_wren_i && (reserved_q != '0)) begin
            reserved_d = reserved_d - CNT_W'(1);
        end
    end

    // Reservation counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignment so all registers update from pre-edge values.
        if (!rst_n) begin
            reserved_q <= '0;
        end else begin
            reserved_q <= reserved_d;
        end
    end

    // A word arriving with nothing reserved means the read engine and this block disagree.
    assert property (@(posedge clk) disable iff (!rst_n) !(fifo_wren_i && (reserved_q == '0)));

endmodule

// File: rtl/sgdmac_burst_splitter.sv
// Splits one scatter-gather command into AXI read bursts of at most
// MAX_BEATS words that never cross a 4 KB page, issuing each burst only
// when the data FIFO has room for all of its beats.
module sgdmac_burst_splitter
    import sgdmac_pkg::*;
#(
    parameter int FIFO_DEPTH = 128,
    parameter int MAX_BEATS  = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cmd_valid_i,
    output logic                         cmd_ready_o,
    input  logic [CMD_W-1:0]             cmd_i,
    output logic                         burst_valid_o,
    input  logic                         burst_ready_i,
    output logic [31:0]                  burst_addr_o,
    output logic [3:0]                   burst_len_o,
    output logic                         burst_last_o,
    input  logic [$clog2(FIFO_DEPTH):0]  fifo_cnt_i,
    input  logic                         fifo_wren_i,
    output logic                         done_o
);

    sgdmac_cmd_t     cmd;
    splitter_state_e state_q;
    splitter_state_e state_d;

    logic [31:0]        addr_q;
    logic [13:0]        remaining_q;
    logic [3:0]         len_q;
    logic               last_q;
    logic [BEATS_W-1:0] beats;
    logic [13:0]        page_words;
    logic [13:0]        calc_beats;
    logic               burst_hs;
    logic               space_ok;
    logic               no_reservation;
    logic               unused_cmd_bits;

    assign cmd             = sgdmac_cmd_t'(cmd_i);
    // Sub-word address and length bits are dropped; transfers are whole words.
    assign unused_cmd_bits = ^{cmd.addr[1:0], cmd.byte_len[1:0]};

    assign beats      = BEATS_W'(len_q) + BEATS_W'(1);
    // Words left before the next 4 KB boundary; at least 1 since addr is word aligned.
    assign page_words = 14'(PAGE_BYTES / 4) - 14'(addr_q[11:2]);
    assign calc_beats = min_words(min_words(remaining_q, 14'(MAX_BEATS)), page_words);
    assign burst_hs   = burst_valid_o && burst_ready_i;

    assign burst_addr_o = addr_q;
    assign burst_len_o  = len_q;
    assign burst_last_o = last_q;
    assign done_o       = (state_q == IDLE) && no_reservation && !cmd_valid_i;

    sgdmac_space_tracker #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_space_tracker (
        .clk         (clk),
        .rst_n       (rst_n),
        .fifo_cnt_i  (fifo_cnt_i),
        .fifo_wren_i (fifo_wren_i),
        .issue_i     (burst_hs),
        .beats_i     (beats),
        .space_ok_o  (space_ok),
        .idle_o      (no_reservation)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and handshake outputs; valid depends only on registered state and space.
    always_comb begin
        state_d       = state_q;
        cmd_ready_o   = 1'b0;
        burst_valid_o = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready_o = 1'b1;
                if (cmd_valid_i && (cmd.byte_len[15:2] != '0)) begin
                    state_d = CALC;
                end
            end
            CALC: begin
                state_d = ISSUE;
            end
            ISSUE: begin
                burst_valid_o = space_ok;
                if (space_ok && burst_ready_i) begin
                    state_d = last_q ? IDLE : CALC;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Command latch, burst sizing and progress through the transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q      <= '0;
            remaining_q <= '0;
            len_q       <= '0;
            last_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid_i) begin
                        addr_q      <= {cmd.addr[31:2], 2'b00};
                        remaining_q <= cmd.byte_len[15:2];
                    end
                end
                CALC: begin
                    len_q  <= 4'(calc_beats - 14'd1);
                    last_q <= (calc_beats == remaining_q);
                end
                ISSUE: begin
                    if (burst_hs) begin
                        addr_q      <= addr_q + 32'({beats, 2'b00});
                        remaining_q <= remaining_q - 14'(beats);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sgdmac_burst_splitter.sv
// Self-checking bench for sgdmac_burst_splitter: a table of commands with
// their expected bursts feeds a scoreboard, plus directed sequences for
// space stalls, zero-length commands and reset during ISSUE.
module tb_sgdmac_burst_splitter;
    import sgdmac_pkg::*;

    localparam int FIFO_DEPTH = 128;
    localparam int MAX_BEATS  = 16;
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;
    localparam int NV         = 15;

    typedef struct {
        bit          new_cmd;
        logic [31:0] cmd_addr;
        logic [15:0] cmd_len;
        logic [31:0] exp_addr;
        logic [3:0]  exp_len;
        logic        exp_last;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  len;
        logic        last;
    } burst_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [CMD_W-1:0] cmd;
    logic             burst_valid;
    logic             burst_ready;
    logic [31:0]      burst_addr;
    logic [3:0]       burst_len;
    logic             burst_last;
    logic [CNT_W-1:0] fifo_cnt;
    logic             fifo_wren;
    logic             done;

    int     n_checks = 0;
    int     n_fail   = 0;
    int     pending  = 0;
    bit     drain_en;
    burst_t exp_q[$];
    vec_t   vecs[NV];

    sgdmac_burst_splitter #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .MAX_BEATS  (MAX_BEATS)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_valid_i   (cmd_valid),
        .cmd_ready_o   (cmd_ready),
        .cmd_i         (cmd),
        .burst_valid_o (burst_valid),
        .burst_ready_i (burst_ready),
        .burst_addr_o  (burst_addr),
        .burst_len_o   (burst_len),
        .burst_last_o  (burst_last),
        .fifo_cnt_i    (fifo_cnt),
        .fifo_wren_i   (fifo_wren),
        .done_o        (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic send_cmd(input logic [31:0] a, input logic [15:0] l);
        bit ok = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd       = {a, l};
        for (int k = 0; k < 200 && !ok; k++) begin
            #4;
            ok = cmd_ready;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        check("cmd_accept", 64'(ok), 64'd1);
    endtask

    task automatic wait_idle(input string name);
        bit ok = 1'b0;
        for (int k = 0; k < 400 && !ok; k++) begin
            @(negedge clk);
            #4;
            ok = (exp_q.size() == 0) && (pending == 0) && done;
        end
        check(name, 64'(ok), 64'd1);
    endtask

    // Read-data model plus burst monitor: words of every accepted burst are
    // written back one per cycle, and each handshake is scored.
    initial begin
        burst_t e;
        fifo_wren = 1'b0;
        forever begin
            @(negedge clk);
            if (drain_en && (pending > 0) && rst_n) begin
                fifo_wren = 1'b1;
                pending--;
            end else begin
                fifo_wren = 1'b0;
            end
            #4;
            if (rst_n && burst_valid && burst_ready) begin
                pending += int'(burst_len) + 1;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL burst_unexpected: got addr 0x%0h len %0d, expected none", burst_addr, burst_len);
                end else begin
                    e = exp_q.pop_front();
                    check("burst_addr", 64'(burst_addr), 64'(e.addr));
                    check("burst_len",  64'(burst_len),  64'(e.len));
                    check("burst_last", 64'(burst_last), 64'(e.last));
                end
            end
        end
    end

    initial begin
        bit          flag;
        logic [36:0] snap;

        vecs[0]  = '{1'b1, 32'h0000_1000, 16'd64,  32'h0000_1000, 4'd15, 1'b1};
        vecs[1]  = '{1'b1, 32'h0000_1000, 16'd200, 32'h0000_1000, 4'd15, 1'b0};
        vecs[2]  = '{1'b0, 32'h0,         16'd0,   32'h0000_1040, 4'd15, 1'b0};
        vecs[3]  = '{1'b0, 32'h0,         16'd0,   32'h0000_1080, 4'd15, 1'b0};
        vecs[4]  = '{1'b0, 32'h0,         16'd0,   32'h0000_10C0, 4'd1,  1'b1};
        vecs[5]  = '{1'b1, 32'h0000_1FF0, 16'd64,  32'h0000_1FF0, 4'd3,  1'b0};
        vecs[6]  = '{1'b0, 32'h0,         16'd0,   32'h0000_2000, 4'd11, 1'b1};
        vecs[7]  = '{1'b1, 32'h0000_2003, 16'd19,  32'h0000_2000, 4'd3,  1'b1};
        vecs[8]  = '{1'b1, 32'h0000_0FFC, 16'd8,   32'h0000_0FFC, 4'd0,  1'b0};
        vecs[9]  = '{1'b0, 32'h0,         16'd0,   32'h0000_1000, 4'd0,  1'b1};
        vecs[10] = '{1'b1, 32'h0000_3FC0, 16'd64,  32'h0000_3FC0, 4'd15, 1'b1};
        vecs[11] = '{1'b1, 32'h0000_7F80, 16'd256, 32'h0000_7F80, 4'd15, 1'b0};
        vecs[12] = '{1'b0, 32'h0,         16'd0,   32'h0000_7FC0, 4'd15, 1'b0};
        vecs[13] = '{1'b0, 32'h0,         16'd0,   32'h0000_8000, 4'd15, 1'b0};
        vecs[14] = '{1'b0, 32'h0,         16'd0,   32'h0000_8040, 4'd15, 1'b1};

        cmd_valid   = 1'b0;
        cmd         = '0;
        burst_ready = 1'b1;
        fifo_cnt    = '0;
        drain_en    = 1'b1;
        rst_n       = 1'b1;
        #1 rst_n    = 1'b0;
        #2;
        check("rst_cmd_ready",   64'(cmd_ready),   64'd1);
        check("rst_burst_valid", 64'(burst_valid), 64'd0);
        check("rst_burst_addr",  64'(burst_addr),  64'd0);
        check("rst_burst_len",   64'(burst_len),   64'd0);
        check("rst_burst_last",  64'(burst_last),  64'd0);
        check("rst_done",        64'(done),        64'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Table-driven commands: push the expected bursts, then send.
        for (int i = 0; i < NV; i++) begin
            if (vecs[i].new_cmd) begin
                for (int j = i; j < NV && (j == i || !vecs[j].new_cmd); j++) begin
                    exp_q.push_back('{vecs[j].exp_addr, vecs[j].exp_len, vecs[j].exp_last});
                end
                send_cmd(vecs[i].cmd_addr, vecs[i].cmd_len);
                wait_idle("table_cmd_done");
            end
        end

        // Space stall: 8 words free, 16 needed.
        drain_en    = 1'b0;
        burst_ready = 1'b0;
        fifo_cnt    = CNT_W'(120);
        exp_q.push_back('{32'h0000_4000, 4'd15, 1'b1});
        send_cmd(32'h0000_4000, 16'd64);
        flag = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            #4;
            flag |= burst_valid;
        end
        check("stall_valid_low", 64'(flag), 64'd0);
        @(negedge clk);
        fifo_cnt = CNT_W'(112);
        #4;
        check("space_exact_valid", 64'(burst_valid), 64'd1);
        snap = {burst_valid, burst_addr, burst_len};
        flag = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #4;
            if ({burst_valid, burst_addr, burst_len} !== snap || burst_last !== 1'b1) flag = 1'b1;
        end
        check("hold_stable", 64'(flag), 64'd0);
        @(negedge clk);
        burst_ready = 1'b1;
        @(negedge clk);
        fifo_cnt = '0;
        drain_en = 1'b1;
        #1;
        check("done_low_reserved", 64'(done), 64'd0);
        wait_idle("stall_cmd_done");

        // Zero-length command: popped, never bursts.
        send_cmd(32'h0000_3000, 16'd3);
        flag = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #4;
            if (!cmd_ready || burst_valid) flag = 1'b1;
        end
        check("zero_len_idle", 64'(flag), 64'd0);
        wait_idle("zero_len_done");

        // Reset while ISSUE holds a valid burst.
        burst_ready = 1'b0;
        send_cmd(32'h0000_5000, 16'd64);
        flag = 1'b0;
        for (int k = 0; k < 20 && !flag; k++) begin
            @(negedge clk);
            #4;
            flag = burst_valid;
        end
        check("issue_valid_seen", 64'(flag), 64'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_cmd_ready",   64'(cmd_ready),   64'd1);
        check("mid_rst_burst_valid", 64'(burst_valid), 64'd0);
        check("mid_rst_burst_addr",  64'(burst_addr),  64'd0);
        check("mid_rst_burst_len",   64'(burst_len),   64'd0);
        check("mid_rst_burst_last",  64'(burst_last),  64'd0);
        check("mid_rst_done",        64'(done),        64'd1);
        @(negedge clk);
        rst_n       = 1'b1;
        burst_ready = 1'b1;
        exp_q.push_back('{32'h0000_6000, 4'd1, 1'b1});
        send_cmd(32'h0000_6000, 16'd8);
        wait_idle("post_reset_cmd_done");

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sgdmac_burst_splitter.md
# sgdmac_burst_splitter

Splits one scatter-gather transfer command (start address + byte length), popped from the read command FIFO, into AXI-legal read bursts for the read engine's AR path. Each burst is at most `MAX_BEATS` words and never crosses a 4 KB boundary. A burst is issued only when the shared data FIFO has room for every beat of it. The block sits between the read command FIFO and the read engine, and tracks space already reserved by in-flight bursts.

## Interface
- `FIFO_DEPTH`, 128: data FIFO depth in 32-bit words; must be ≥ `MAX_BEATS`.
- `MAX_BEATS`, 16: maximum beats per burst; legal range 1..16.
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cmd_valid_i`  in  1  command FIFO not empty.
- `cmd_ready_o`  out  1  command pop.
- `cmd_i`  in  48  [47:16] byte address, [15:0] byte length.
- `burst_valid_o`  out  1  burst request valid.
- `burst_ready_i`  in  1  burst request accepted.
- `burst_addr_o`  out  32  burst start address, word aligned.
- `burst_len_o`  out  4  beats−1 (AXI ARLEN encoding).
- `burst_last_o`  out  1  final burst of the current command.
- `fifo_cnt_i`  in  $clog2(FIFO_DEPTH)+1  current data FIFO occupancy.
- `fifo_wren_i`  in  1  one word written into the data FIFO this cycle.
- `done_o`  out  1  idle: no command held, no reservation outstanding.

## Operation
- Address and length bits [1:0] are ignored (forced to 0). Words = len[15:2], range 0..16383.
- FSM states:
  - **IDLE**: `cmd_ready_o` = 1. On handshake, latch address and remaining words. If words = 0, stay in IDLE (command dropped); otherwise go to CALC.
  - **CALC**: compute `beats = min(remaining, MAX_BEATS, (4096 − addr[11:0]) >> 2)` and register it. `last = (beats == remaining)`. Go to ISSUE.
  - **ISSUE**: drive the burst outputs from registers. `burst_valid_o` = (free ≥ beats). On handshake: `addr += beats*4`, `remaining −= beats`, `reserved += beats`. Then go to IDLE if last, else CALC.
- Space accounting:
  - `free = FIFO_DEPTH − fifo_cnt_i − reserved`, using unsigned arithmetic one bit wider than `fifo_cnt_i`.
  - `reserved` is a counter of $clog2(FIFO_DEPTH)+1 bits.
  - Each cycle: `reserved` increments by beats on a burst handshake and decrements by 1 on `fifo_wren_i`. When both occur in the same cycle the net change is applied.
  - `fifo_wren_i` while `reserved` = 0 saturates at 0 and fires a simulation assertion.
- `done_o` = (state == IDLE) && (reserved == 0) && !cmd_valid_i.

## Timing
- Reset values:
  - `cmd_ready_o` = 1 (state IDLE).
  - `burst_valid_o`, `burst_last_o`, `burst_addr_o`, `burst_len_o` = 0.
  - `reserved` = 0, `done_o` = 1.
- Latency: command handshake at cycle N → `burst_valid_o` at N+2 at the earliest. Each non-final burst handshake is followed by a one-cycle CALC bubble.
- `burst_valid_o` must not depend on `burst_ready_i`.
- Once `burst_valid_o` is asserted, it and the payload hold until the handshake. This holds because free is non-decreasing while no burst is issued: a write moves one word from reserved into cnt, and a FIFO read only raises free.
- `cmd_ready_o` is high only in IDLE. A new command is accepted no earlier than the cycle after the final burst handshake.
- 4 KB rule: beats always ≥ 1 because addr[11:0] ≤ 0xFFC. The address never wraps past 2^32 for legal commands.
- Reset mid-operation (any state): return to IDLE immediately and clear `reserved`. The in-flight command is lost.

## Structure
- Shared package `sgdmac_pkg` holds:
  - `sgdmac_cmd_t` packed struct {addr[31:0], byte_len[15:0]} and `CMD_W` = 48;
  - `AXI_MAX_BEATS` = 16, `PAGE_BYTES` = 4096;
  - the FSM state enum `splitter_state_e` {IDLE, CALC, ISSUE}.
- One natural sub-module: `sgdmac_space_tracker`, which holds the reserved counter, the free computation and the sufficiency compare against beats.

## Test plan
- Single burst: cmd addr 0x1000, len 64 → one burst: addr 0x1000, len 15, last = 1. `done_o` returns to 1 after 16 `fifo_wren_i`.
- Multi-burst: addr 0x1000, len 200 → bursts at 0x1000/0x1040/0x1080 with len 15 each, then 0x10C0 len 1 with last = 1 only on the fourth.
- Page split: addr 0x1FF0, len 64 → burst 0x1FF0 len 3, then 0x2000 len 11 with last = 1.
- Space stall: `fifo_cnt_i` = 120, `reserved` = 0, beats 16 → valid stays low. Lower cnt to 112 → valid rises. With `burst_ready_i` held low for 5 cycles, valid and payload stay stable.
- Zero length: addr 0x3000, len 3 → command popped, no burst, `cmd_ready_o` stays 1.
- Reset in ISSUE with valid high → all outputs at reset values in the same cycle. The next command is processed normally from IDLE.
